reg_file_mp: RTL and testbench

//   Parametrised multi-port register file: one byte-masked write port, two independent

---
 rtl/reg_file_mp.sv | 99 +++++++++
 tb/tb_reg_file_mp.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with byte-masked write, two registered read ports, forwarding and bulk clear
// Ports: clk/rst (async, active-low); wr_en/wr_addr/wr_data/wr_be write port;
//   rd0_*/rd1_* read ports (en, addr in; data, valid out, one-cycle latency);
//   clr_req starts a sweep that zeroes one entry per cycle while busy is high;
//   addr_err pulses for any accepted request with an address beyond DEPTH-1.
module reg_file_mp #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic              rd0_valid,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_valid,
  input  logic              clr_req,
  output logic              busy,
  output logic              addr_err
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_err;
  logic [1:0]          r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data [2];
  logic                w_busy, w_wr_in, w_wr_ok, w_err;
  logic [DATA_W-1:0]   w_mask, w_wr_old, w_wr_merged;
  logic [1:0]          w_rd_en, w_rd_in, w_rd_ok;
  logic [ADDR_W-1:0]   w_rd_addr [2];
  logic [DATA_W-1:0]   w_rd_val [2];
  assign w_busy      = r_state == S_CLEAR;
  assign w_wr_in     = {1'b0, wr_addr} < DEPTH_A;
  assign w_wr_ok     = wr_en && !w_busy && w_wr_in && !(ZERO_REG != 0 && wr_addr == '0);
  assign w_wr_old    = r_mem[w_wr_in ? wr_addr : '0];
  assign w_wr_merged = (wr_data & w_mask) | (w_wr_old & ~w_mask);
  assign w_rd_en     = {rd1_en, rd0_en};
  assign w_rd_addr[0] = rd0_addr;
  assign w_rd_addr[1] = rd1_addr;
  assign w_err       = !w_busy && ((wr_en && !w_wr_in) || |(w_rd_en & ~w_rd_in));
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NB; i++) w_mask[8*i +: 8] = {8{wr_be[i]}};
  end
  // A read hitting the address being written this cycle sees the merged value.
  always_comb begin
    w_rd_in = '0;
    w_rd_ok = '0;
    for (int p = 0; p < 2; p++) begin
      w_rd_in[p]  = {1'b0, w_rd_addr[p]} < DEPTH_A;
      w_rd_ok[p]  = w_rd_en[p] && !w_busy;
      w_rd_val[p] = (!w_rd_in[p] || (ZERO_REG != 0 && w_rd_addr[p] == '0)) ? '0 :
                    (w_wr_ok && w_rd_addr[p] == wr_addr) ? w_wr_merged :
                    r_mem[w_rd_in[p] ? w_rd_addr[p] : '0];
    end
  end
  always_comb begin
    w_next = S_IDLE;
    w_next = w_busy ? (r_cnt == LAST ? S_IDLE : S_CLEAR) : (clr_req ? S_CLEAR : S_IDLE);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_rd_valid   <= '0;
      r_rd_data[0] <= '0;
      r_rd_data[1] <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= (w_busy && r_cnt != LAST) ? r_cnt + 1'b1 : '0;
      r_err      <= w_err;
      r_rd_valid <= w_rd_ok;
      for (int p = 0; p < 2; p++) if (w_rd_ok[p]) r_rd_data[p] <= w_rd_val[p];
      if (w_busy) r_mem[r_cnt] <= '0;
      else if (w_wr_ok) r_mem[wr_addr] <= w_wr_merged;
    end
  end
  assign rd0_data  = r_rd_data[0];
  assign rd1_data  = r_rd_data[1];
  assign rd0_valid = r_rd_valid[0];
  assign rd1_valid = r_rd_valid[1];
  assign busy      = w_busy;
  assign addr_err  = r_err;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench over three configurations (default, DEPTH=6, ZERO_REG=1)
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, rd0_en = 1'b0, rd1_en = 1'b0, clr_req = 1'b0;
  logic [2:0]  wr_addr = '0, rd0_addr = '0, rd1_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic [15:0] rd0_data [3];
  logic [15:0] rd1_data [3];
  logic        rd0_valid [3];
  logic        rd1_valid [3];
  logic        busy [3];
  logic        addr_err [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    reg_file_mp #(.DATA_W(16), .DEPTH(g == 1 ? 6 : 8), .ADDR_W(3), .ZERO_REG(g == 2 ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data[g]), .rd0_valid(rd0_valid[g]),
      .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data[g]), .rd1_valid(rd1_valid[g]),
      .clr_req(clr_req), .busy(busy[g]), .addr_err(addr_err[g])
    );
  end
  typedef struct {logic [15:0] d0, d1; logic v0, v1, b, e;} exp_t;
  exp_t        sb [$];
  logic [15:0] m_mem [3][8];
  logic [15:0] m_d0 [3];
  logic [15:0] m_d1 [3];
  logic        m_busy [3];
  int          m_cnt [3];
  int          n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 8; a++) m_mem[k][a] = '0;
      m_d0[k] = '0; m_d1[k] = '0; m_busy[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask
  function automatic logic [15:0] rval(input int k, input logic [2:0] a, input bit wok, input logic [15:0] merged);
    int d = (k == 1) ? 6 : 8;
    if (int'(a) >= d || (k == 2 && a == 0)) return '0;
    if (wok && a == wr_addr) return merged;
    return m_mem[k][a];
  endfunction
  task automatic cycle();
    for (int k = 0; k < 3; k++) begin
      int          d = (k == 1) ? 6 : 8;
      bit          bz = m_busy[k];
      bit          wok = wr_en && !bz && int'(wr_addr) < d && !(k == 2 && wr_addr == 0);
      logic [15:0] mask = {{8{wr_be[1]}}, {8{wr_be[0]}}};
      logic [15:0] merged = (wr_data & mask) | (m_mem[k][wr_addr] & ~mask);
      exp_t        e;
      e.v0 = rd0_en && !bz;
      e.v1 = rd1_en && !bz;
      if (e.v0) m_d0[k] = rval(k, rd0_addr, wok, merged);
      if (e.v1) m_d1[k] = rval(k, rd1_addr, wok, merged);
      e.d0 = m_d0[k];
      e.d1 = m_d1[k];
      e.e = !bz && ((wr_en && int'(wr_addr) >= d) || (rd0_en && int'(rd0_addr) >= d) || (rd1_en && int'(rd1_addr) >= d));
      if (bz) begin
        m_mem[k][m_cnt[k]] = '0;
        if (m_cnt[k] == d - 1) m_busy[k] = 1'b0;
        m_cnt[k]++;
      end else begin
        if (wok) m_mem[k][wr_addr] = merged;
        if (clr_req) begin m_busy[k] = 1'b1; m_cnt[k] = 0; end
      end
      e.b = m_busy[k];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk($sformatf("d%0d.sb_empty", k), 32'd1, 32'd0);
        continue;
      end
      e = sb.pop_front();
      chk($sformatf("d%0d.rd0_valid", k), 32'(rd0_valid[k]), 32'(e.v0));
      chk($sformatf("d%0d.rd1_valid", k), 32'(rd1_valid[k]), 32'(e.v1));
      chk($sformatf("d%0d.rd0_data", k), 32'(rd0_data[k]), 32'(e.d0));
      chk($sformatf("d%0d.rd1_data", k), 32'(rd1_data[k]), 32'(e.d1));
      chk($sformatf("d%0d.busy", k), 32'(busy[k]), 32'(e.b));
      chk($sformatf("d%0d.addr_err", k), 32'(addr_err[k]), 32'(e.e));
    end
  endtask
  task automatic drv(input bit we, input logic [2:0] wa, input logic [15:0] wd, input logic [1:0] be,
                     input bit r0, input logic [2:0] a0, input bit r1, input logic [2:0] a1, input bit clr);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd0_en = r0; rd0_addr = a0; rd1_en = r1; rd1_addr = a1; clr_req = clr;
    cycle();
  endtask
  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic chk_reset_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.d%0d.busy", tag, k), 32'(busy[k]), 32'd0);
      chk($sformatf("%s.d%0d.rd0_valid", tag, k), 32'(rd0_valid[k]), 32'd0);
      chk($sformatf("%s.d%0d.rd1_valid", tag, k), 32'(rd1_valid[k]), 32'd0);
      chk($sformatf("%s.d%0d.rd0_data", tag, k), 32'(rd0_data[k]), 32'd0);
      chk($sformatf("%s.d%0d.rd1_data", tag, k), 32'(rd1_data[k]), 32'd0);
      chk($sformatf("%s.d%0d.addr_err", tag, k), 32'(addr_err[k]), 32'd0);
    end
  endtask
  initial begin
    model_reset();
    #7;
    chk_reset_state("reset");
    rst = 1'b1;
    for (int a = 0; a < 8; a++) drv(0, 0, 0, 0, 1, 3'(a), 1, 3'(7 - a), 0);
    drv(1, 3, 16'hA5A5, 2'b11, 0, 0, 0, 0, 0);
    drv(1, 3, 16'h1234, 2'b01, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 3, 1, 3, 0);
    drv(1, 2, 16'h1111, 2'b11, 0, 0, 0, 0, 0);
    drv(1, 5, 16'hBEEF, 2'b11, 1, 5, 1, 2, 0);
    drv(0, 5, 16'hFFFF, 2'b11, 1, 5, 0, 0, 0);
    drv(1, 4, 16'h7777, 2'b00, 1, 4, 0, 0, 0);
    for (int a = 0; a < 8; a++) drv(1, 3'(a), 16'($urandom), 2'b11, 0, 0, 0, 0, 0);
    drv(1, 1, 16'hCAFE, 2'b11, 1, 1, 1, 6, 1);
    for (int i = 0; i < 10; i++) drv(1, 3'(i), 16'hDEAD, 2'b11, 1, 3'(i), 1, 3'(7 - i), 1);
    for (int a = 0; a < 8; a++) drv(0, 0, 0, 0, 1, 3'(a), 1, 3'(a), 0);
    drv(1, 7, 16'h4242, 2'b11, 1, 7, 0, 0, 0);
    idle();
    drv(0, 0, 0, 0, 1, 7, 1, 6, 0);
    drv(1, 0, 16'hFFFF, 2'b11, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++)
      drv($urandom_range(0, 1), 3'($urandom), 16'($urandom), 2'($urandom),
          $urandom_range(0, 1), 3'($urandom), $urandom_range(0, 1), 3'($urandom), $urandom_range(0, 19) == 0);
    for (int i = 0; i < 10; i++) idle();
    for (int a = 0; a < 8; a++) drv(1, 3'(a), 16'h5A5A + 16'(a), 2'b11, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 2, 1, 4, 1);
    for (int i = 0; i < 3; i++) idle();
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state("midclr");
    model_reset();
    #2;
    rst = 1'b1;
    for (int a = 0; a < 8; a++) drv(0, 0, 0, 0, 1, 3'(a), 1, 3'(a), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
